// File: rtl/fpu_mul_seq.sv
// Multi-cycle IEEE-754 multiplier: shift-add significand product, STEP_BITS per cycle,
// one-cycle round/normalise, valid/ready handshakes on both sides.
module fpu_mul_seq #(
  parameter int BIT_WIDTH = 32,
  parameter int STEP_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_mode,
  input  logic [BIT_WIDTH-1:0] i_inputA,
  input  logic [BIT_WIDTH-1:0] i_inputB,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [BIT_WIDTH-1:0] o_output,
  output logic                 o_inexact,
  output logic                 o_overflow,
  output logic                 o_underflow,
  output logic                 o_invalid
);
  localparam int EXP_WIDTH = (BIT_WIDTH == 128) ? 15 : (BIT_WIDTH == 64) ? 11 : 8;
  localparam int SGN_WIDTH = BIT_WIDTH - EXP_WIDTH;
  localparam int MAN_W     = SGN_WIDTH - 1;
  localparam int BIAS      = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int CYC       = (SGN_WIDTH + STEP_BITS - 1) / STEP_BITS;
  localparam int LO_W      = CYC * STEP_BITS;
  localparam int PW        = SGN_WIDTH + LO_W;
  localparam int EW2       = EXP_WIDTH + 2;
  localparam int CNT_W     = $clog2(CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ROUND, S_DONE} state_t;

  state_t                 state_q;
  logic [SGN_WIDTH-1:0]   mcand_q, hi_q;
  logic [LO_W-1:0]        mplier_q, lo_q;
  logic signed [EW2-1:0]  exp_q;
  logic                   sign_q;
  logic [2:0]             mode_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ready_q, valid_q;
  logic [BIT_WIDTH-1:0]   out_q;
  logic                   inexact_q, overflow_q, underflow_q, invalid_q;

  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_output    = out_q;
  assign o_inexact   = inexact_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
  assign o_invalid   = invalid_q;

  // Operand classification, evaluated combinationally on the live inputs for the accept edge.
  logic [EXP_WIDTH-1:0] exp_a, exp_b;
  logic [MAN_W-1:0]     man_a, man_b;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, sign_d;
  logic signed [EW2-1:0] exp_sum_d;

  assign exp_a  = i_inputA[BIT_WIDTH-2 -: EXP_WIDTH];
  assign exp_b  = i_inputB[BIT_WIDTH-2 -: EXP_WIDTH];
  assign man_a  = i_inputA[MAN_W-1:0];
  assign man_b  = i_inputB[MAN_W-1:0];
  assign a_zero = (exp_a == '0);
  assign b_zero = (exp_b == '0);
  assign a_inf  = (&exp_a) && (man_a == '0);
  assign b_inf  = (&exp_b) && (man_b == '0);
  assign a_nan  = (&exp_a) && (man_a != '0);
  assign b_nan  = (&exp_b) && (man_b != '0);
  assign a_snan = a_nan && !man_a[MAN_W-1];
  assign b_snan = b_nan && !man_b[MAN_W-1];
  assign sign_d = i_inputA[BIT_WIDTH-1] ^ i_inputB[BIT_WIDTH-1];
  assign exp_sum_d = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - $signed(EW2'(BIAS));

  logic [BIT_WIDTH-1:0] qnan_c;
  assign qnan_c = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // One shift-add step: hi + multiplicand * digit; the low STEP_BITS retire into lo.
  logic [STEP_BITS-1:0]           digit;
  logic [SGN_WIDTH+STEP_BITS-1:0] step_sum;
  assign digit    = mplier_q[STEP_BITS-1:0];
  assign step_sum = {{STEP_BITS{1'b0}}, hi_q}
                  + ({{STEP_BITS{1'b0}}, mcand_q} * {{SGN_WIDTH{1'b0}}, digit});

  // Normalise and round the completed product.
  logic [PW-1:0]          prod;
  logic [2*SGN_WIDTH-1:0] p2, norm;
  logic [SGN_WIDTH-1:0]   mant;
  logic                   guard, sticky, inc, carry, ovf, unf;
  logic [SGN_WIDTH:0]     rnd;
  logic [MAN_W-1:0]       frac_r;
  logic signed [EW2-1:0]  exp_n, exp_r;
  logic [2:0]             rm;
  logic [BIT_WIDTH-1:0]   round_res_d;

  assign prod = {hi_q, lo_q};
  assign p2   = prod[2*SGN_WIDTH-1:0];

  always_comb begin
    norm   = p2[2*SGN_WIDTH-1] ? p2 : (p2 << 1);
    exp_n  = exp_q + $signed({{(EW2-1){1'b0}}, p2[2*SGN_WIDTH-1]});
    mant   = norm[2*SGN_WIDTH-1:SGN_WIDTH];
    guard  = norm[SGN_WIDTH-1];
    sticky = |norm[SGN_WIDTH-2:0];
    rm     = (mode_q > 3'd4) ? 3'd0 : mode_q;
    case (rm)
      3'd0:    inc = guard & (sticky | mant[0]);
      3'd1:    inc = guard;
      3'd2:    inc = (guard | sticky) & ~sign_q;
      3'd3:    inc = (guard | sticky) & sign_q;
      default: inc = 1'b0;
    endcase
    rnd    = {1'b0, mant} + {{SGN_WIDTH{1'b0}}, inc};
    carry  = rnd[SGN_WIDTH];
    frac_r = carry ? rnd[SGN_WIDTH-1:1] : rnd[MAN_W-1:0];
    exp_r  = exp_n + $signed({{(EW2-1){1'b0}}, carry});
    ovf    = (exp_r >= $signed(EW2'((1 << EXP_WIDTH) - 1)));
    unf    = (exp_r <= $signed(EW2'(0)));
    if (ovf) begin
      if (rm == 3'd4 || (rm == 3'd2 && sign_q) || (rm == 3'd3 && !sign_q))
        round_res_d = {sign_q, {(EXP_WIDTH-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      else
        round_res_d = {sign_q, {EXP_WIDTH{1'b1}}, {MAN_W{1'b0}}};
    end else if (unf) begin
      round_res_d = {sign_q, {(BIT_WIDTH-1){1'b0}}};
    end else begin
      round_res_d = {sign_q, exp_r[EXP_WIDTH-1:0], frac_r};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      mode_q      <= 3'd0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      out_q       <= '0;
      inexact_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (i_valid) begin
          mode_q   <= i_mode;
          sign_q   <= sign_d;
          exp_q    <= exp_sum_d;
          mcand_q  <= {1'b1, man_a};
          mplier_q <= LO_W'({1'b1, man_b});
          hi_q     <= '0;
          lo_q     <= '0;
          cnt_q    <= '0;
          ready_q  <= 1'b0;
          if (a_nan || b_nan || a_inf || b_inf || a_zero || b_zero) begin
            state_q     <= S_DONE;
            valid_q     <= 1'b1;
            inexact_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            if (a_nan || b_nan) begin
              out_q     <= qnan_c;
              invalid_q <= a_snan | b_snan;
            end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
              out_q     <= qnan_c;
              invalid_q <= 1'b1;
            end else if (a_inf || b_inf) begin
              out_q     <= {sign_d, {EXP_WIDTH{1'b1}}, {MAN_W{1'b0}}};
              invalid_q <= 1'b0;
            end else begin
              out_q     <= {sign_d, {(BIT_WIDTH-1){1'b0}}};
              invalid_q <= 1'b0;
            end
          end else begin
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          hi_q     <= step_sum[SGN_WIDTH+STEP_BITS-1:STEP_BITS];
          lo_q     <= {step_sum[STEP_BITS-1:0], lo_q[LO_W-1:STEP_BITS]};
          mplier_q <= mplier_q >> STEP_BITS;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(CYC - 1)) state_q <= S_ROUND;
        end
        S_ROUND: begin
          out_q       <= round_res_d;
          inexact_q   <= guard | sticky | ovf | unf;
          overflow_q  <= ovf;
          underflow_q <= unf & ~ovf;
          invalid_q   <= 1'b0;
          valid_q     <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: if (i_ready) begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_mul_seq.sv
// Scoreboarded bench for fpu_mul_seq (binary32, STEP_BITS=4): directed vectors,
// back-pressure hold and an asynchronous abort in the middle of MUL.
module tb_fpu_mul_seq;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [2:0]  i_mode = 3'd0;
  logic [31:0] i_inputA = '0;
  logic [31:0] i_inputB = '0;
  logic        o_ready, o_valid, o_inexact, o_overflow, o_underflow, o_invalid;
  logic [31:0] o_output;

  fpu_mul_seq #(.BIT_WIDTH(32), .STEP_BITS(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .i_inputA(i_inputA), .i_inputB(i_inputB),
    .o_valid(o_valid), .i_ready(i_ready), .o_output(o_output),
    .o_inexact(o_inexact), .o_overflow(o_overflow),
    .o_underflow(o_underflow), .o_invalid(o_invalid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;  // {invalid, overflow, underflow, inexact}
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam int LAT_NORM = 7;  // edges after the accept edge, CYC+1
  localparam int LAT_SPEC = 0;  // result registered on the accept edge itself

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {o_invalid, o_overflow, o_underflow, o_inexact};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                        input logic [31:0] res, input logic [3:0] flg,
                        input int lat, input int hold);
    exp_t        e;
    int          n;
    logic [31:0] held;
    @(negedge i_clk);
    check_val("ready_idle", {31'd0, o_ready}, 32'd1);
    i_valid  = 1'b1;
    i_inputA = a;
    i_inputB = b;
    i_mode   = m;
    @(posedge i_clk);
    e.res = res;
    e.flg = flg;
    exp_q.push_back(e);
    #1;
    i_valid  = 1'b0;
    i_inputA = $urandom;
    i_inputB = $urandom;
    i_mode   = 3'($urandom_range(0, 7));
    n = 0;
    while (!o_valid && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check_val("edges_after_accept", n, lat);
    e = exp_q.pop_front();
    check_val("result", o_output, e.res);
    check_val("flags", {28'd0, flags_now()}, {28'd0, e.flg});
    held = o_output;
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      check_val("hold_output", o_output, held);
      check_val("hold_ready", {31'd0, o_ready}, 32'd0);
      check_val("hold_valid", {31'd0, o_valid}, 32'd1);
    end
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    check_val("valid_drop", {31'd0, o_valid}, 32'd0);
    $display("txn %08h * %08h mode %0d -> %08h flags %04b latency %0d", a, b, m, held, e.flg, n);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge i_clk);
    check_val("rst_ready", {31'd0, o_ready}, 32'd1);
    check_val("rst_valid", {31'd0, o_valid}, 32'd0);
    check_val("rst_output", o_output, 32'd0);
    check_val("rst_flags", {28'd0, flags_now()}, 32'd0);
    i_rst_n = 1'b1;

    run_op(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 4'b0000, LAT_NORM, 5);
    run_op(32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 4'b0001, LAT_NORM, 0);
    run_op(32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800003, 4'b0001, LAT_NORM, 0);
    run_op(32'h3F800001, 32'h3F800001, 3'd4, 32'h3F800002, 4'b0001, LAT_NORM, 0);
    run_op(32'h7F000000, 32'h40000000, 3'd0, 32'h7F800000, 4'b0101, LAT_NORM, 0);
    run_op(32'h7F000000, 32'h40000000, 3'd4, 32'h7F7FFFFF, 4'b0101, LAT_NORM, 0);
    run_op(32'hFF000000, 32'h40000000, 3'd2, 32'hFF7FFFFF, 4'b0101, LAT_NORM, 0);
    run_op(32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 4'b0011, LAT_NORM, 0);
    run_op(32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 4'b0001, LAT_NORM, 0);
    run_op(32'h3F800003, 32'h3FC00000, 3'd1, 32'h3FC00005, 4'b0001, LAT_NORM, 0);
    run_op(32'h3F800003, 32'h3FC00000, 3'd5, 32'h3FC00004, 4'b0001, LAT_NORM, 0);
    run_op(32'hBF800001, 32'h3F800001, 3'd3, 32'hBF800003, 4'b0001, LAT_NORM, 0);
    run_op(32'h00000000, 32'h7F800000, 3'd0, 32'h7FC00000, 4'b1000, LAT_SPEC, 0);
    run_op(32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 4'b0000, LAT_SPEC, 0);
    run_op(32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 4'b1000, LAT_SPEC, 0);
    run_op(32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 4'b0000, LAT_SPEC, 0);
    run_op(32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 4'b0000, LAT_SPEC, 0);
    run_op(32'h7F800000, 32'h7F800000, 3'd0, 32'h7F800000, 4'b0000, LAT_SPEC, 0);

    // Abort during the third MUL cycle; nothing may come out afterwards.
    @(negedge i_clk);
    i_valid  = 1'b1;
    i_inputA = 32'h3FC00000;
    i_inputB = 32'h40000000;
    i_mode   = 3'd0;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check_val("abort_ready", {31'd0, o_ready}, 32'd1);
    check_val("abort_valid", {31'd0, o_valid}, 32'd0);
    check_val("abort_output", o_output, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge i_clk);
      #1;
      if (o_valid) seen++;
    end
    check_val("abort_no_result", seen, 0);
    check_val("abort_ready_after", {31'd0, o_ready}, 32'd1);
    $display("txn abort mid-MUL: valid pulses after release %0d", seen);

    run_op(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 4'b0000, LAT_NORM, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
